multicycle_control: RTL

Main control state machine for the multicycle datapath. It sequences one instruction at a time through fetch, decode, execute, memory and writeback. It drives the `ALUOp` code that `ALUControl` turns into the ALU function, and it drives all datapath mux selects and write enables. It also stalls on a memory ready handshake and flags unsupported opcodes.

---
 rtl/multicycle_control_if.sv | 33 +++
 rtl/multicycle_control.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle main controller and the datapath:
// opcode and memory handshake in, mux selects and write enables out.
interface multicycle_control_if;
  logic [5:0] Op;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       ALUSrcA;
  logic [1:0] ALUOp;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  Op, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegWrite, RegDst, ALUSrcA, ALUOp, ALUSrcB, PCSource, illegal_op, state
  );

  modport slave (
    output Op, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegWrite, RegDst, ALUSrcA, ALUOp, ALUSrcB, PCSource, illegal_op, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle datapath: fetch/decode/execute/memory/
// writeback sequencing with memory-ready stalls and illegal opcode flagging.
module multicycle_control (
  input  logic clk,
  input  logic reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t state_q, state_d;
  logic   op_legal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    op_legal = (bus.Op == OP_RTYPE) || (bus.Op == OP_LW) || (bus.Op == OP_SW) ||
               (bus.Op == OP_BEQ)   || (bus.Op == OP_J)  || (bus.Op == OP_ADDI);
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.Op)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (bus.Op == OP_SW)      state_d = S_MEMWR;
        else if (bus.Op == OP_LW) state_d = S_MEMRD;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Reset gates every output so nothing is written while the machine is held.
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUOp       = 2'b00;
    bus.ALUSrcB     = 2'b00;
    bus.PCSource    = 2'b00;
    bus.illegal_op  = 1'b0;
    bus.state       = reset ? 4'd0 : state_q;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          bus.MemRead = 1'b1;
          bus.ALUSrcB = 2'b01;
          bus.IRWrite = bus.mem_ready;
          bus.PCWrite = bus.mem_ready;
        end
        S_DECODE: begin
          bus.ALUSrcB    = 2'b11;
          bus.illegal_op = !op_legal;
        end
        S_MEMADR, S_ADDIEX: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          bus.MemRead = 1'b1;
          bus.IorD    = 1'b1;
        end
        S_MEMWB: begin
          bus.MemtoReg = 1'b1;
          bus.RegWrite = 1'b1;
        end
        S_MEMWR: begin
          bus.MemWrite = 1'b1;
          bus.IorD     = 1'b1;
        end
        S_EXEC: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUOp   = 2'b10;
        end
        S_ALUWB: begin
          bus.RegDst   = 1'b1;
          bus.RegWrite = 1'b1;
        end
        S_BRANCH: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALUOp       = 2'b01;
          bus.PCWriteCond = 1'b1;
          bus.PCSource    = 2'b01;
        end
        S_JUMP: begin
          bus.PCWrite  = 1'b1;
          bus.PCSource = 2'b10;
        end
        S_ADDIWB: bus.RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
